// File: rtl/delta_decoder_pkg.sv
// delta_decoder_pkg: shared constants and FSM state encoding for the delta decoder.
package delta_decoder_pkg;

    localparam int DATAWIDTH_DEF = 64;

    // IDLE: no seed held yet; RUN: accumulator holds a valid running sample
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/delta_dec_acc.sv
// delta_dec_acc: combinational accumulator step, Acc + DIFF.
// Default build wraps modulo 2^W. With DELTA_DECODER_SAT_EN defined, Acc is
// unsigned, DIFF signed, the result clamps to [0, 2^W-1] and o_sat flags a clamp.
import delta_decoder_pkg::*;

module delta_dec_acc #(
    parameter int W = DATAWIDTH_DEF
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_diff,
`ifdef DELTA_DECODER_SAT_EN
    output logic         o_sat,
`endif
    output logic [W-1:0] o_sum
);

`ifdef DELTA_DECODER_SAT_EN
    // Two guard bits: bit W+1 marks a negative result, bit W an overflow
    logic [W+1:0] w_ext;

    // Widened add, then clamp to the unsigned range
    always_comb begin
        w_ext = {2'b00, i_acc} + {{2{i_diff[W-1]}}, i_diff};
        o_sum = w_ext[W-1:0];
        o_sat = 1'b0;
        if (w_ext[W+1]) begin
            o_sum = '0;
            o_sat = 1'b1;
        end else if (w_ext[W]) begin
            o_sum = '1;
            o_sat = 1'b1;
        end
    end
`else
    // Plain modulo add: exact inverse of a modulo differencer
    assign o_sum = i_acc + i_diff;
`endif

endmodule

// File: rtl/delta_decoder.sv
// delta_decoder: reconstructs samples from a difference stream with a
// valid/ready handshake on both sides and a one-deep registered output.
// Optional feature: define DELTA_DECODER_SAT_EN for saturating accumulation
// and an extra o_sat output.
import delta_decoder_pkg::*;

module delta_decoder #(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sync,
    input  logic [DATAWIDTH-1:0] i_diff,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    output logic [DATAWIDTH-1:0] o_q,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
`ifdef DELTA_DECODER_SAT_EN
    output logic                 o_sat,
`endif
    output logic                 o_err
);

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_acc;
    logic [DATAWIDTH-1:0] r_q;
    logic                 r_out_valid;
    logic                 r_err;
    logic [DATAWIDTH-1:0] w_sum;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
`ifdef DELTA_DECODER_SAT_EN
    logic                 r_sat;
    logic                 w_sat;
`endif

    delta_dec_acc #(.W(DATAWIDTH)) u_acc (
        .i_acc  (r_acc),
        .i_diff (i_diff),
`ifdef DELTA_DECODER_SAT_EN
        .o_sat  (w_sat),
`endif
        .o_sum  (w_sum)
    );

    // Output slot is free, or it empties this cycle: full throughput
    assign o_in_ready = !r_out_valid || i_out_ready;
    assign w_in_xfer  = i_in_valid && o_in_ready;
    assign w_out_xfer = r_out_valid && i_out_ready;

    assign o_q         = r_q;
    assign o_out_valid = r_out_valid;
    assign o_err       = r_err;
`ifdef DELTA_DECODER_SAT_EN
    assign o_sat       = r_sat;
`endif

    // FSM, accumulator and output register; an accepted word overrides the
    // output-drain clear so a simultaneous in/out transfer keeps OutValid high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_q         <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
`ifdef DELTA_DECODER_SAT_EN
            r_sat       <= 1'b0;
`endif
        end else begin
            if (w_out_xfer) begin
                r_out_valid <= 1'b0;
`ifdef DELTA_DECODER_SAT_EN
                r_sat       <= 1'b0;
`endif
            end
            if (w_in_xfer) begin
                if (i_sync) begin
                    // Seed (or reseed): absolute value, Err untouched
                    r_state     <= ST_RUN;
                    r_acc       <= i_diff;
                    r_q         <= i_diff;
                    r_out_valid <= 1'b1;
`ifdef DELTA_DECODER_SAT_EN
                    r_sat       <= 1'b0;
`endif
                end else if (r_state == ST_IDLE) begin
                    // Difference with no reference: drop it, flag sticky error
                    r_err <= 1'b1;
                end else begin
                    r_acc       <= w_sum;
                    r_q         <= w_sum;
                    r_out_valid <= 1'b1;
`ifdef DELTA_DECODER_SAT_EN
                    r_sat       <= w_sat;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_delta_decoder.sv
// tb_delta_decoder: directed checks plus a randomized stream with stalls,
// compared against a sample-level reference model, at DATAWIDTH=8.
module tb_delta_decoder;

    localparam int W = 8;
    localparam int N = 1000;

    logic         clk;
    logic         rst_n;
    logic         sync;
    logic [W-1:0] diff;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] q;
    logic         out_valid;
    logic         out_ready;
    logic         err;
`ifdef DELTA_DECODER_SAT_EN
    logic         sat;
`endif

    int tests = 0;
    int fails = 0;

    delta_decoder #(.DATAWIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sync      (sync),
        .i_diff      (diff),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_q         (q),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
`ifdef DELTA_DECODER_SAT_EN
        .o_sat       (sat),
`endif
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference stream: absolute samples, and the words a modulo differencer emits
    logic [W-1:0] smp   [N];
    logic [W-1:0] wdiff [N];
    logic         wsync [N];

    initial begin
        int prev;
        int cur;
        int idx;
        int outcnt;
        int cyc;
        bit model_ov;
        bit in_x;
        bit out_x;
        logic [W-1:0] hold_q;

        rst_n = 1'b0; sync = 1'b0; diff = '0; in_valid = 1'b0; out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_q", q, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_inrdy", in_ready, 1);
        tick();
        rst_n = 1'b1;

        // Seed then two differences, back-to-back
        in_valid = 1'b1; sync = 1'b1; diff = 8'h10;
        tick();
        chk("seq_q0", q, 8'h10);
        chk("seq_ov0", out_valid, 1);
        sync = 1'b0; diff = 8'h05;
        tick();
        chk("seq_q1", q, 8'h15);
        diff = 8'hFE;
        tick();
        chk("seq_q2", q, 8'h13);
        in_valid = 1'b0;
        tick();
        chk("seq_drain", out_valid, 0);

        // Difference before any seed
        rst_n = 1'b0; #1; rst_n = 1'b1;
        in_valid = 1'b1; sync = 1'b0; diff = 8'h03;
        tick();
        chk("noseed_ov", out_valid, 0);
        chk("noseed_err", err, 1);
        sync = 1'b1; diff = 8'h20;
        tick();
        chk("seed_q", q, 8'h20);
        chk("seed_err", err, 1);

        // Overflow boundary: 0xF0 + 0x20
        diff = 8'hF0;
        tick();
        sync = 1'b0; diff = 8'h20;
        tick();
`ifdef DELTA_DECODER_SAT_EN
        chk("ovf_q", q, 8'hFF);
        chk("ovf_sat", sat, 1);
`else
        chk("ovf_q", q, 8'h10);
`endif

        // Backpressure: 3 stalled cycles with a word pending
        hold_q = q;
        out_ready = 1'b0; diff = 8'h01;
        #1;
        chk("stall_inrdy", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_q", q, hold_q);
            chk("stall_ov", out_valid, 1);
            chk("stall_inrdy", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_inrdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef DELTA_DECODER_SAT_EN
        chk("release_q", q, 8'hFF);
        chk("release_sat", sat, 1);
`else
        chk("release_q", q, 8'h11);
`endif
        tick();
        chk("release_drain", out_valid, 0);

        // Asynchronous reset while output is held
        in_valid = 1'b1; sync = 1'b1; diff = 8'h77; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_q", q, 8'h77);
        #2; rst_n = 1'b0; #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_q", q, 0);
        chk("arst_err", err, 0);
        chk("arst_inrdy", in_ready, 1);
        #1; rst_n = 1'b1;
        tick();
        in_valid = 1'b1; sync = 1'b0; diff = 8'h05; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("arst_idle_ov", out_valid, 0);
        chk("arst_idle_err", err, 1);

        // Random stream: samples take signed steps of at most 127, so the
        // saturating build reconstructs exactly as well
        prev = 0;
        for (int k = 0; k < N; k++) begin
            if (k == 0 || $urandom_range(0, 49) == 0) begin
                cur = $urandom_range(0, 255);
                wsync[k] = 1'b1;
                wdiff[k] = cur[W-1:0];
            end else begin
                cur = prev + $urandom_range(0, 254) - 127;
                if (cur < 0) cur = 0;
                if (cur > 255) cur = 255;
                wsync[k] = 1'b0;
                wdiff[k] = 8'(cur - prev);
            end
            smp[k] = cur[W-1:0];
            prev = cur;
        end

        rst_n = 1'b0; #1; rst_n = 1'b1;
        idx = 0; outcnt = 0; cyc = 0; model_ov = 1'b0;
        while (outcnt < N && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (idx < N) && ($urandom_range(0, 4) != 0);
            sync      = (idx < N) ? wsync[idx] : 1'b0;
            diff      = (idx < N) ? wdiff[idx] : '0;
            #1;
            in_x  = in_valid && (!model_ov || out_ready);
            out_x = model_ov && out_ready;
            if (cyc % 16 == 0) chk("rnd_inrdy", in_ready, (!model_ov || out_ready));
            if (out_x) begin
                chk("rnd_q", q, smp[outcnt]);
                outcnt++;
            end
            @(posedge clk); #1;
            if (in_x) begin
                model_ov = 1'b1;
                idx++;
            end else if (out_x) begin
                model_ov = 1'b0;
            end
            if (cyc % 16 == 0) chk("rnd_ov", out_valid, model_ov);
            cyc++;
        end
        in_valid = 1'b0;
        chk("rnd_done", outcnt, N);
        chk("rnd_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
